pwr_seq_arbiter: RTL
====================

Name: pwr_seq_arbiter

Overview:
- Central scheduler for up to N_DOM power-gated domains. Each domain has its own iso_en, ret_en and pse controls.
- Accepts a per-domain level request to be off or on.
- Runs at most one power-down or power-up sequence at a time, which limits switch inrush.
- Arbitrates pending domains round-robin and holds each step for a fixed cycle count.
- Sits above the per-domain power switches and replaces free-running per-domain sequencers.

Parameters:
- N_DOM, 4, number of managed domains (2..8).
- STEP_DLY, 4, cycles each sequence step is held (minimum 1; 0 is illegal and must raise an elaboration error).
- CNT_W, 4, step counter width; must satisfy 2**CNT_W > STEP_DLY.

Ports:
- CLK  in  1  clock, all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- req_off  in  N_DOM  level per domain: 1 = domain requested off, 0 = requested on.
- iso_en  out  N_DOM  isolation enable per domain (1 = isolated).
- ret_en  out  N_DOM  retention save enable per domain (1 = retain).
- pse  out  N_DOM  power switch enable per domain (1 = powered).
- dom_off  out  N_DOM  committed state per domain (1 = fully off).
- busy  out  1  a sequence is in progress.
- grant_id  out  clog2(N_DOM)  domain currently or last sequenced.
- done  out  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (async, while RST_N=0):
  - iso_en=0, ret_en=0, pse=all 1, dom_off=0.
  - busy=0, grant_id=0, done=0, FSM=IDLE, step counter=0, RR pointer=N_DOM-1.
  - Reset mid-sequence forces every domain straight to the ON encoding; no ordering is guaranteed.
- Pending domain: any d with req_off[d] != dom_off[d].
- All outputs are registered. Only the granted domain's bits change during a sequence.
- FSM states: IDLE, DN_ISO, DN_RET, DN_PSW, UP_PSW, UP_RST, UP_ISO.
- IDLE:
  - If any domain is pending, the arbiter picks winner g: the first pending index at or after ptr+1, modulo N_DOM.
  - At the same edge: grant_id<=g, ptr<=g, busy<=1, counter<=STEP_DLY-1.
  - Next state is DN_ISO if dom_off[g]=0, else UP_PSW.
- Entry actions (applied at the transition edge) and exits (each state exits when counter==0; otherwise counter decrements):
  - DN_ISO: iso_en[g]<=1. Exits to DN_RET.
  - DN_RET: ret_en[g]<=1. Exits to DN_PSW.
  - DN_PSW: pse[g]<=0. Exits to IDLE with dom_off[g]<=1.
  - UP_PSW: pse[g]<=1. Exits to UP_RST.
  - UP_RST: ret_en[g]<=0. Exits to UP_ISO.
  - UP_ISO: iso_en[g]<=0. Exits to IDLE with dom_off[g]<=0.
  - Each non-IDLE transition edge reloads counter<=STEP_DLY-1.
- At the final exit edge: done<=1 for one cycle and busy<=0.
- IDLE lasts at least one cycle between sequences. The next grant occurs no earlier than the edge after done is asserted.
- Latency: from the edge that samples a pending request, a full sequence takes 3*STEP_DLY edges until done rises.
- Requests changing during a sequence are ignored; the sequence always completes. A reversed request is serviced as a new sequence later.
- Steady encodings: ON = iso/ret/pse 0/0/1; OFF = 1/1/0. Intermediate steps are always break-before-make.
- Requests are assumed synchronous to CLK.

Optional Feature:
- Macro: PWR_SEQ_WAKE_PRIO_EN.
- Defined: in IDLE, pending power-up domains (dom_off=1, req_off=0) win over pending power-down domains. Round-robin applies within each class, and the pointer updates identically.
- Undefined: a single round-robin over all pending domains, direction ignored.

Decomposition:
- Package pwr_seq_pkg holds:
  - the FSM state enum (3-bit encoding, IDLE=0);
  - steady encodings PWR_ON=3'b001 and PWR_OFF=3'b110 for {iso,ret,pse};
  - a clog2 helper constant function.
- Sub-module pwr_rr_arbiter:
  - combinational pick of the first set bit of a pending vector starting at ptr+1;
  - outputs grant index and valid;
  - instantiated twice (wake class and sleep class) when PWR_SEQ_WAKE_PRIO_EN is defined, once otherwise.

Test Plan (N_DOM=4, STEP_DLY=4):
- Reset release with req_off=0000 -> iso_en=0000, ret_en=0000, pse=1111, busy=0 for 20 cycles.
- req_off=0001 at cycle 0:
  - iso_en[0] rises after edge 1, ret_en[0] after edge 5, pse[0] falls after edge 9;
  - done pulses after edge 13 and dom_off=0001.
- req_off back to 0000 from the OFF state -> pse[0]=1, then ret_en[0]=0, then iso_en[0]=0 at 4-cycle spacing; dom_off=0000 and done pulses once.
- req_off=1111 simultaneously -> grants in order 0,1,2,3. Each sequence takes 12 cycles, separated by 1 IDLE cycle, with never more than one grant_id active.
- Reversal mid-sequence: req_off[2] goes 1 then 0 during DN_RET -> the down sequence completes (dom_off[2]=1), then an up sequence follows and ends with dom_off[2]=0.
- RST_N low during DN_PSW of domain 1 -> all outputs immediately at reset values; after release with req_off=0000 no sequence starts.
- With PWR_SEQ_WAKE_PRIO_EN: domain 3 off and ptr=3; set req_off[0]=1 and req_off[3]=0 together -> domain 3 is granted first.

Source files
------------

// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the power-sequencing arbiter.
package pwr_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DN_ISO = 3'd1,
        S_DN_RET = 3'd2,
        S_DN_PSW = 3'd3,
        S_UP_PSW = 3'd4,
        S_UP_RST = 3'd5,
        S_UP_ISO = 3'd6
    } pwr_state_e;

    // Steady {iso, ret, pse} encodings.
    localparam logic [2:0] PWR_ON  = 3'b001;
    localparam logic [2:0] PWR_OFF = 3'b110;

    function automatic int pwr_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/pwr_rr_arbiter.sv
// Combinational round-robin pick: first set bit of pend at or after ptr+1, wrapping.
module pwr_rr_arbiter
    import pwr_seq_pkg::*;
#(
    parameter int N_DOM = 4,
    parameter int ID_W  = pwr_clog2(N_DOM)
) (
    input  logic [N_DOM-1:0] pend,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_vld
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = ptr;
        for (int i = 0; i < N_DOM; i++) begin
            idx = (idx == ID_W'(N_DOM - 1)) ? '0 : idx + 1'b1;
            if (pend[idx] && !gnt_vld) begin
                gnt_id  = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwr_seq_arbiter.sv
// Single-sequence power-gating scheduler for N_DOM domains.
// Optional PWR_SEQ_WAKE_PRIO_EN: pending power-ups win over pending power-downs.
module pwr_seq_arbiter
    import pwr_seq_pkg::*;
#(
    parameter int  N_DOM    = 4,
    parameter int  STEP_DLY = 4,
    parameter int  CNT_W    = 4,
    localparam int ID_W     = pwr_clog2(N_DOM)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_DOM-1:0] req_off,
    output logic [N_DOM-1:0] iso_en,
    output logic [N_DOM-1:0] ret_en,
    output logic [N_DOM-1:0] pse,
    output logic [N_DOM-1:0] dom_off,
    output logic             busy,
    output logic [ID_W-1:0]  grant_id,
    output logic             done
);

    if (STEP_DLY < 1) begin : g_bad_dly
        $error("pwr_seq_arbiter: STEP_DLY must be at least 1");
    end
    if ((1 << CNT_W) <= STEP_DLY) begin : g_bad_cnt
        $error("pwr_seq_arbiter: CNT_W too narrow for STEP_DLY");
    end
    if (N_DOM < 2 || N_DOM > 8) begin : g_bad_ndom
        $error("pwr_seq_arbiter: N_DOM must be 2..8");
    end

    localparam logic [CNT_W-1:0] CNT_RLD = CNT_W'(STEP_DLY - 1);

    pwr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  gid_q, gid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N_DOM-1:0] iso_q, iso_d, ret_q, ret_d, pse_q, pse_d, off_q, off_d;

    logic [N_DOM-1:0] pend;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_vld;

    assign pend = req_off ^ off_q;

`ifdef PWR_SEQ_WAKE_PRIO_EN
    logic [ID_W-1:0] up_id, dn_id;
    logic            up_vld, dn_vld;

    pwr_rr_arbiter #(.N_DOM(N_DOM), .ID_W(ID_W)) u_arb_wake (
        .pend(pend & off_q), .ptr(ptr_q), .gnt_id(up_id), .gnt_vld(up_vld));
    pwr_rr_arbiter #(.N_DOM(N_DOM), .ID_W(ID_W)) u_arb_sleep (
        .pend(pend & ~off_q), .ptr(ptr_q), .gnt_id(dn_id), .gnt_vld(dn_vld));

    assign gnt_id  = up_vld ? up_id : dn_id;
    assign gnt_vld = up_vld | dn_vld;
`else
    pwr_rr_arbiter #(.N_DOM(N_DOM), .ID_W(ID_W)) u_arb (
        .pend(pend), .ptr(ptr_q), .gnt_id(gnt_id), .gnt_vld(gnt_vld));
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= ID_W'(N_DOM - 1);
            gid_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            iso_q   <= {N_DOM{PWR_ON[2]}};
            ret_q   <= {N_DOM{PWR_ON[1]}};
            pse_q   <= {N_DOM{PWR_ON[0]}};
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            iso_q   <= iso_d;
            ret_q   <= ret_d;
            pse_q   <= pse_d;
            off_q   <= off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        iso_d   = iso_q;
        ret_d   = ret_q;
        pse_d   = pse_q;
        off_d   = off_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    gid_d  = gnt_id;
                    ptr_d  = gnt_id;
                    busy_d = 1'b1;
                    cnt_d  = CNT_RLD;
                    if (off_q[gnt_id]) begin
                        state_d        = S_UP_PSW;
                        pse_d[gnt_id]  = 1'b1;
                    end else begin
                        state_d        = S_DN_ISO;
                        iso_d[gnt_id]  = 1'b1;
                    end
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = CNT_RLD;
                    case (state_q)
                        S_DN_ISO: begin state_d = S_DN_RET; ret_d[gid_q] = 1'b1; end
                        S_DN_RET: begin state_d = S_DN_PSW; pse_d[gid_q] = 1'b0; end
                        S_UP_PSW: begin state_d = S_UP_RST; ret_d[gid_q] = 1'b0; end
                        S_UP_RST: begin state_d = S_UP_ISO; iso_d[gid_q] = 1'b0; end
                        default: begin
                            // Final step of either direction: commit and release.
                            state_d      = S_IDLE;
                            cnt_d        = '0;
                            off_d[gid_q] = (state_q == S_DN_PSW);
                            done_d       = 1'b1;
                            busy_d       = 1'b0;
                        end
                    endcase
                end
            end
        endcase
    end

    assign iso_en   = iso_q;
    assign ret_en   = ret_q;
    assign pse      = pse_q;
    assign dom_off  = off_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;
    assign done     = done_q;

endmodule
